// File: rtl/timer_pkg.sv
// Shared constants and helpers for the descending timer and its prescaler.
package timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // A divide-by-1 prescaler still needs a one-bit counter to stay legal.
  function automatic int prescale_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/prescale_tick.sv
// Free-running prescaler: emits one tick every PRESCALE enabled cycles.
module prescale_tick
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("prescale_tick: PRESCALE must be >= 1");
  end

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/counter_down_timer.sv
// Loadable descending timer with prescaler, pause/resume and one-shot or
// periodic reload; used for bit-slot and poll-interval timing.
module counter_down_timer
  import timer_pkg::*;
#(
  parameter int W        = 8,
  parameter int M        = 35,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  output logic [W-1:0] count,
  output logic         empty,
  output logic         done,
  output logic         running
);

  if (M >= (1 << W)) begin : g_bad_reset_value
    $error("counter_down_timer: M must be < 2**W");
  end

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_down_timer: PRESCALE must be >= 1");
  end

  logic [W-1:0] reload_reg;
  logic         start_ok;
  logic         pre_en;
  logic         pre_clr;
  logic         tick;

  // The prescaler only advances on cycles where no higher-priority command
  // acts, so a stop or load freezes/clears it rather than letting it slip.
  assign start_ok = start && !stop && !running;
  assign pre_clr  = load || start_ok;
  assign pre_en   = running && !load && !stop;

  prescale_tick #(
    .PRESCALE(PRESCALE)
  ) u_prescale (
    .clk  (clk),
    .reset(reset),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      reload_reg <= W'(M);
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        reload_reg <= load_val;
        count      <= load_val;
        if (load_val == '0 || stop) begin
          running <= 1'b0;
        end else if (start) begin
          running <= 1'b1;
        end
      end else if (stop) begin
        running <= 1'b0;
      end else if (start_ok) begin
        // Starting from empty reloads first; an empty reload expires at once.
        if (count == '0) begin
          if (reload_reg == '0) begin
            done <= 1'b1;
          end else begin
            count   <= reload_reg;
            running <= 1'b1;
          end
        end else begin
          running <= 1'b1;
        end
      end else if (tick) begin
        if (count == W'(1)) begin
          done <= 1'b1;
          if (mode == MODE_PERIODIC && reload_reg != '0) begin
            count <= reload_reg;
          end else begin
            count   <= '0;
            running <= 1'b0;
          end
        end else if (count != '0) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  assign empty = (count == '0);

endmodule

// File: tb/tb_counter_down_timer.sv
// Scoreboard bench: every driven cycle queues the state expected after the
// next edge, and a negedge monitor pops and compares it.
module tb_counter_down_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;

  logic [7:0] countMain, countPre;
  logic       emptyMain, emptyPre;
  logic       doneMain, donePre;
  logic       runningMain, runningPre;

  int compareCount = 0;
  int mismatchCount = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] count;
    logic       done;
    logic       running;
  } expEntry_t;

  expEntry_t expQueue[$];

  always #5 clk = ~clk;

  counter_down_timer dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .mode(mode),
    .count(countMain), .empty(emptyMain), .done(doneMain), .running(runningMain)
  );

  counter_down_timer #(.W(8), .M(35), .PRESCALE(4)) dutPre (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .mode(mode),
    .count(countPre), .empty(emptyPre), .done(donePre), .running(runningPre)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of commands and queue the state expected after the edge.
  task automatic applyStimulus(input string tag, input int sel, input logic rs,
                               input logic ld, input logic [7:0] lv,
                               input logic st, input logic sp, input logic md,
                               input logic [7:0] ec, input logic ed, input logic er);
    reset = rs; load = ld; load_val = lv; start = st; stop = sp; mode = md;
    @(posedge clk);
    expQueue.push_back('{tag, sel, ec, ed, er});
    #1;
    reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic idle(input string tag, input int sel, input logic md,
                      input logic [7:0] ec, input logic ed, input logic er);
    applyStimulus(tag, sel, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, md, ec, ed, er);
  endtask

  always @(negedge clk) begin
    if (expQueue.size() > 0) begin
      expEntry_t e;
      e = expQueue.pop_front();
      if (e.sel == 0) begin
        checkOutput({e.tag, ".count"}, 32'(countMain), 32'(e.count));
        checkOutput({e.tag, ".done"}, 32'(doneMain), 32'(e.done));
        checkOutput({e.tag, ".running"}, 32'(runningMain), 32'(e.running));
        checkOutput({e.tag, ".empty"}, 32'(emptyMain), 32'(e.count == 8'd0));
      end else begin
        checkOutput({e.tag, ".count"}, 32'(countPre), 32'(e.count));
        checkOutput({e.tag, ".done"}, 32'(donePre), 32'(e.done));
        checkOutput({e.tag, ".running"}, 32'(runningPre), 32'(e.running));
        checkOutput({e.tag, ".empty"}, 32'(emptyPre), 32'(e.count == 8'd0));
      end
    end
  end

  initial begin
    int r;

    // Reset, then a default start reloads M=35 and counts out.
    applyStimulus("t1.reset", 0, 1, 0, 0, 0, 0, 0, 8'd0, 0, 0);
    applyStimulus("t1.start", 0, 0, 0, 0, 1, 0, 0, 8'd35, 0, 1);
    for (int k = 1; k <= 35; k++)
      idle($sformatf("t1.k%0d", k), 0, 0, 8'(35 - k), k == 35, k != 35);
    idle("t1.after0", 0, 0, 8'd0, 0, 0);
    idle("t1.after1", 0, 0, 8'd0, 0, 0);

    // Prescaled one-shot: load+start together, decrement every 4 edges.
    applyStimulus("t2.reset", 1, 1, 0, 0, 0, 0, 0, 8'd0, 0, 0);
    applyStimulus("t2.loadstart", 1, 0, 1, 8'd3, 1, 0, 0, 8'd3, 0, 1);
    for (int i = 1; i <= 12; i++)
      idle($sformatf("t2.e%0d", i), 1, 0, 8'(3 - i / 4), i == 12, i < 12);
    for (int i = 0; i < 20; i++)
      idle($sformatf("t2.hold%0d", i), 1, 0, 8'd0, 0, 0);

    // Periodic reload of 5 for four periods, then stop freezes the count.
    applyStimulus("t3.load", 0, 0, 1, 8'd5, 0, 0, 1, 8'd5, 0, 0);
    applyStimulus("t3.start", 0, 0, 0, 0, 1, 0, 1, 8'd5, 0, 1);
    for (int i = 1; i <= 20; i++) begin
      r = i % 5;
      idle($sformatf("t3.c%0d", i), 0, 1, (r == 0) ? 8'd5 : 8'(5 - r), r == 0, 1);
    end
    applyStimulus("t3.stop", 0, 0, 0, 0, 0, 1, 1, 8'd5, 0, 0);
    for (int i = 0; i < 3; i++)
      idle($sformatf("t3.frozen%0d", i), 0, 1, 8'd5, 0, 0);

    // Pause and resume, then stop+start in one cycle stays paused.
    applyStimulus("t4.load", 0, 0, 1, 8'd10, 0, 0, 0, 8'd10, 0, 0);
    applyStimulus("t4.start", 0, 0, 0, 0, 1, 0, 0, 8'd10, 0, 1);
    for (int i = 1; i <= 4; i++)
      idle($sformatf("t4.dec%0d", i), 0, 0, 8'(10 - i), 0, 1);
    applyStimulus("t4.stop", 0, 0, 0, 0, 0, 1, 0, 8'd6, 0, 0);
    for (int i = 0; i < 7; i++)
      idle($sformatf("t4.paused%0d", i), 0, 0, 8'd6, 0, 0);
    applyStimulus("t4.resume", 0, 0, 0, 0, 1, 0, 0, 8'd6, 0, 1);
    for (int i = 1; i <= 6; i++)
      idle($sformatf("t4.run%0d", i), 0, 0, 8'(6 - i), i == 6, i != 6);
    applyStimulus("t4.load4", 0, 0, 1, 8'd4, 0, 0, 0, 8'd4, 0, 0);
    applyStimulus("t4.stopstart", 0, 0, 0, 0, 1, 1, 0, 8'd4, 0, 0);
    idle("t4.stillpaused0", 0, 0, 8'd4, 0, 0);
    idle("t4.stillpaused1", 0, 0, 8'd4, 0, 0);

    // Loading zero while running halts silently; starting on zero reload pulses.
    applyStimulus("t5.load9", 0, 0, 1, 8'd9, 0, 0, 0, 8'd9, 0, 0);
    applyStimulus("t5.start", 0, 0, 0, 0, 1, 0, 0, 8'd9, 0, 1);
    idle("t5.c8", 0, 0, 8'd8, 0, 1);
    idle("t5.c7", 0, 0, 8'd7, 0, 1);
    applyStimulus("t5.load0", 0, 0, 1, 8'd0, 0, 0, 0, 8'd0, 0, 0);
    idle("t5.quiet", 0, 0, 8'd0, 0, 0);
    applyStimulus("t5.startzero", 0, 0, 0, 0, 1, 0, 0, 8'd0, 1, 0);
    idle("t5.pulseonce", 0, 0, 8'd0, 0, 0);

    // Reset mid-count restores M as the reload value.
    applyStimulus("t6.load14", 0, 0, 1, 8'd14, 0, 0, 0, 8'd14, 0, 0);
    applyStimulus("t6.start", 0, 0, 0, 0, 1, 0, 0, 8'd14, 0, 1);
    idle("t6.c13", 0, 0, 8'd13, 0, 1);
    idle("t6.c12", 0, 0, 8'd12, 0, 1);
    applyStimulus("t6.reset", 0, 1, 0, 0, 0, 0, 0, 8'd0, 0, 0);
    applyStimulus("t6.start", 0, 0, 0, 0, 1, 0, 0, 8'd35, 0, 1);
    for (int i = 1; i <= 3; i++)
      idle($sformatf("t6.c%0d", 35 - i), 0, 0, 8'(35 - i), 0, 1);

    for (int i = 0; i < 4 && expQueue.size() > 0; i++) @(negedge clk);
    #1;
    checkOutput("drain.pending", 32'(expQueue.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/counter_down_timer.md
Name: counter_down_timer

Overview:
Parametrised, loadable descending timer. It generalises the fixed-M down-counter used for N64 bit-timing with the following additions:
- runtime reload value
- clock prescaler
- start/stop (pause/resume) control
- one-shot or periodic mode
- single-cycle expiry pulse

It sits beside the controller serial engine and generates bit-slot and poll-interval timing.

Parameters:
W, 8, counter and reload width in bits
M, 35, reload value after reset; must satisfy M < 2**W, otherwise elaboration error
PRESCALE, 1, clk cycles per decrement; must be >= 1, otherwise elaboration error

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
load  in  1  load load_val into reload register and counter
load_val  in  W  value captured on load
start  in  1  begin or resume counting
stop  in  1  pause counting, count held
mode  in  1  0 = one-shot, 1 = periodic
count  out  W  current counter value (registered)
empty  out  1  high when count == 0 (combinational from count)
done  out  1  one-cycle expiry pulse (registered)
running  out  1  high while counting (registered)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- On reset:
  - count=0, reload_reg=M, running=0, done=0, prescaler=0
  - hence empty=1 out of reset
- Command priority within a cycle: reset > load > stop > start > tick.
- Tick:
  - Internal prescaler counts 0..PRESCALE-1 only while running=1, then wraps.
  - tick = running && prescaler==PRESCALE-1.
  - With PRESCALE=1, tick = running.
- Start:
  - If running=0 and stop=0, start sets running=1 and clears the prescaler.
  - If count==0 at start, count<=reload_reg in the same edge.
  - If count==0 and reload_reg==0: running stays 0 and done pulses for one cycle.
  - start while running=1 is ignored.
- Decrement timing: if start is sampled at edge E0 with count=N>0, count decrements at edges E0+k*PRESCALE for k=1..N.
- Expiry: a tick with count==1.
  - done<=1 for exactly one cycle, set by the expiring edge.
  - mode=0 (one-shot): count<=0 and running<=0 on the same edge.
  - mode=1 (periodic): count<=reload_reg, prescaler continues, running stays 1. Period is reload_reg*PRESCALE cycles. If reload_reg==0, behave as one-shot.
  - mode is sampled only at the expiry tick; changing it mid-count is legal.
- Stop:
  - running<=0; count and prescaler are held.
  - A later start resumes with the prescaler cleared.
  - stop+start in the same cycle: stop wins.
- Load:
  - reload_reg<=load_val, count<=load_val, prescaler cleared, done not asserted.
  - Load while running with load_val>0: keeps running from the new value.
  - Load while running with load_val==0: running<=0, no done pulse.
  - Load+start in the same cycle: value loaded and running<=1 (if load_val>0), with E0 = that edge.
- Reset mid-count overrides everything. No done pulse is generated by reset.
- Arithmetic: count never underflows. Decrement occurs only when count>0; a tick with count==0 is impossible by construction.
- done and empty:
  - In one-shot mode they coincide on the expiry cycle.
  - In periodic mode empty never asserts during counting.

Decomposition:
- Shared package timer_pkg:
  - MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1
  - function for the prescaler width: PW = (PRESCALE>1) ? $clog2(PRESCALE) : 1
- One natural sub-module: prescale_tick (params PRESCALE)
  - ports: clk, reset, en, clr; output tick
  - Contains the prescaler counter, so the top holds only count, reload_reg, running, done and the control priority logic.

Test Plan:
1. Reset -> count=0, empty=1, running=0, done=0. Then start with defaults (M=35, PRESCALE=1) -> count reloads to 35, reaches 0 after 35 further edges, done high exactly 1 cycle, running drops with it.
2. PRESCALE=4, load_val=3, load+start same cycle, mode=0 -> count 3,2,1,0 at edges E0+4, E0+8, E0+12; done once at E0+12; no further change for 20 cycles.
3. mode=1, load_val=5, start -> done pulses every 5 cycles for 4 periods; count sequence 5,4,3,2,1,5,...; empty never high; then stop -> count frozen.
4. Pause/resume: load 10, start, stop after 4 decrements -> count=6 held for 7 cycles, running=0. Start -> resumes 5,4,... and expires after 6 more ticks. stop+start same cycle -> stays paused.
5. Load 0 while running (count=7) -> count=0, running=0, done stays 0. Start with reload_reg=0 -> single done pulse, running stays 0.
6. Reset asserted mid-count (count=12, running) -> next edge count=0, reload_reg=M=35, running=0, no done. Start -> count=35, counting resumes normally.
